// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_e;

  localparam int DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full/empty flags and a sticky
// overflow flag. A write while full is dropped even if a pop happens that cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             accept_s;
  logic             pop_ok_s;

  assign accept_s = push_i && !full_q;
  assign pop_ok_s = pop_i && !empty_q;

  // Pointer, occupancy and flag next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (!accept_s && pop_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (push_i && full_q) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// FIFO-backed byte feeder for the UART transmitter using the dintx/newd/donetx handshake.
// Optional transmit watchdog: define UART_TX_FEEDER_TIMEOUT_EN to add tx_timeout.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy,
  output logic [7:0]             uart_dintx,
  output logic                   uart_newd,
  input  logic                   uart_donetx
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  ,
  output logic                   tx_timeout
`endif
);

  feeder_state_e state_q, state_d;
  byte_t         dintx_q, dintx_d;
  byte_t         fifo_rdata_s;
  logic          fifo_empty_s;
  logic          pop_s;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tx_timeout_q, tx_timeout_d;
`endif

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_en),
    .wdata_i    (wr_data),
    .pop_i      (pop_s),
    .rdata_o    (fifo_rdata_s),
    .full_o     (full),
    .empty_o    (fifo_empty_s),
    .count_o    (count),
    .overflow_o (overflow)
  );

  // Launch FSM: pop in IDLE, pulse newd in LAUNCH, hold the byte until donetx.
  always_comb begin
    state_d = state_q;
    dintx_d = dintx_q;
    pop_s   = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tx_timeout_d = tx_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          dintx_d = fifo_rdata_s;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        tmo_cnt_d = TW'(0);
`endif
      end
      WAIT_DONE: begin
        if (uart_donetx) begin
          state_d = IDLE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the byte; it is not retried.
          state_d      = IDLE;
          tx_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          state_d   = WAIT_DONE;
`else
        end else begin
          state_d = WAIT_DONE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and launched-byte registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dintx_q <= 8'h00;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      tmo_cnt_q    <= TW'(0);
      tx_timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dintx_q <= dintx_d;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tx_timeout_q <= tx_timeout_d;
`endif
    end
  end

  // newd decodes straight from the state register, so it is one clean cycle wide.
  assign uart_newd  = (state_q == LAUNCH);
  assign busy       = (state_q != IDLE);
  assign uart_dintx = dintx_q;
  assign empty      = fifo_empty_s;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  assign tx_timeout = tx_timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, busy, uart_newd;
  logic [2:0] count;
  logic [7:0] uart_dintx;
  logic       uart_donetx = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic       tx_timeout;
`endif

  uart_tx_feeder #(
    .DEPTH (DEPTH)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .busy        (busy),
    .uart_dintx  (uart_dintx),
    .uart_newd   (uart_newd),
    .uart_donetx (uart_donetx)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    .tx_timeout  (tx_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte queue plus transmit phase (0 idle, 1 launching, 2 waiting).
  byte_t m_q[$];
  int    m_phase = 0;
  byte_t m_last = 8'h00;
  bit    m_ovf = 1'b0;
  bit    m_tmo = 1'b0;
  int    m_wcnt = 0;

  task automatic model_update();
    bit acc;
    if (rst) begin
      m_q.delete();
      m_phase = 0; m_last = 8'h00; m_ovf = 1'b0; m_tmo = 1'b0; m_wcnt = 0;
    end else begin
      acc = wr_en && (m_q.size() < DEPTH);
      if (wr_en && !acc) m_ovf = 1'b1;
      if (m_phase == 0) begin
        if (m_q.size() > 0) begin
          m_last  = m_q.pop_front();
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_wcnt  = 0;
      end else begin
        if (uart_donetx) m_phase = 0;
        else if (TMO_EN && m_wcnt == TMO - 1) begin
          m_phase = 0;
          m_tmo   = 1'b1;
        end else m_wcnt++;
      end
      if (acc) m_q.push_back(wr_data);
    end
  endtask

  task automatic model_compare();
    check("m_count", 32'(count), 32'(m_q.size()));
    check("m_full", 32'(full), 32'(m_q.size() == DEPTH));
    check("m_empty", 32'(empty), 32'(m_q.size() == 0));
    check("m_overflow", 32'(overflow), 32'(m_ovf));
    check("m_busy", 32'(busy), 32'(m_phase != 0));
    check("m_newd", 32'(uart_newd), 32'(m_phase == 1));
    check("m_dintx", 32'(uart_dintx), 32'(m_last));
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    check("m_tx_timeout", 32'(tx_timeout), 32'(m_tmo));
`endif
  endtask

  // Cycle driver with an optional donetx responder and launch log.
  int    cyc = 0;
  bit    auto_done = 1'b0;
  bit    rand_delay = 1'b0;
  int    done_delay = 3;
  int    done_at = -1;
  int    last_done = -1;
  int    peak = 0;
  byte_t launched[$];
  int    spacing[$];

  task automatic step(input bit r, input bit w, input byte_t d, input bit dn);
    rst         = r;
    wr_en       = w;
    wr_data     = d;
    uart_donetx = dn | (auto_done && cyc == done_at);
    if (uart_donetx && m_phase == 2 && !r) last_done = cyc;
    @(posedge clk);
    model_update();
    #1;
    model_compare();
    if (r) begin
      done_at   = -1;
      last_done = -1;
    end
    if (uart_newd === 1'b1) begin
      launched.push_back(uart_dintx);
      if (last_done >= 0) spacing.push_back(cyc + 1 - last_done);
      if (rand_delay) done_delay = $urandom_range(0, 8);
      done_at = cyc + 1 + done_delay;
    end
    if (int'(count) > peak) peak = int'(count);
    cyc++;
  endtask

  typedef struct {
    bit    rst; bit wr; byte_t d; bit dn;
    bit    e_newd; byte_t e_dintx; bit e_busy; int e_count; bit e_full; bit e_empty;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit r, input bit w, input byte_t d, input bit dn,
                         input bit en, input byte_t ed, input bit eb, input int ec,
                         input bit ef, input bit ee);
    vec_t v;
    v = '{r, w, d, dn, en, ed, eb, ec, ef, ee};
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    // Single byte (donetx 10 cycles after newd), stray donetx, write+pop overlap.
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 0, 1'b0, 1'b1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].d, vecs[i].dn);
      check($sformatf("vec%0d_newd", i), 32'(uart_newd), 32'(vecs[i].e_newd));
      check($sformatf("vec%0d_dintx", i), 32'(uart_dintx), 32'(vecs[i].e_dintx));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
    end

    // Burst ordering: 01..05 back to back.
    launched.delete(); spacing.delete(); last_done = -1; peak = 0;
    auto_done = 1'b1; done_delay = 3;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, byte_t'(i + 1), 1'b0);
    repeat (60) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("burst_launches", 32'(launched.size()), 32'd5);
    for (int i = 0; i < launched.size() && i < 5; i++)
      check($sformatf("burst_byte%0d", i), 32'(launched[i]), 32'(i + 1));
    check("burst_spacings", 32'(spacing.size()), 32'd4);
    foreach (spacing[i]) check($sformatf("burst_gap%0d", i), 32'(spacing[i]), 32'd2);
    check("burst_peak", 32'(peak), 32'd4);
    check("burst_empty", 32'(empty), 32'd1);

    // Full / overflow with donetx held off.
    launched.delete(); auto_done = 1'b0; done_at = -1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, byte_t'(8'h10 + i), 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_first", 32'(launched.size() == 1 ? launched[0] : 8'hFF), 32'h10);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    auto_done = 1'b1; done_delay = 2;
    repeat (40) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf_launches", 32'(launched.size()), 32'd5);
    for (int i = 0; i < launched.size() && i < 5; i++)
      check($sformatf("ovf_byte%0d", i), 32'(launched[i]), 32'(8'h10 + i));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while waiting with three bytes queued.
    auto_done = 1'b0; done_at = -1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, byte_t'(8'h40 + i), 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rstmid_pre_count", 32'(count), 32'd3);
    check("rstmid_pre_busy", 32'(busy), 32'd1);
    launched.delete();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_newd", 32'(uart_newd), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ovf", 32'(overflow), 32'd0);
    check("rstmid_dintx", 32'(uart_dintx), 32'h00);
    repeat (10) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rstmid_quiet", 32'(launched.size()), 32'd0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Watchdog: no donetx at all; each byte aborts after TMO cycles in WAIT_DONE.
    launched.delete();
    step(1'b0, 1'b1, 8'h77, 1'b0);
    step(1'b0, 1'b1, 8'h88, 1'b0);
    n = 0;
    while (launched.size() == 0 && n < 20) begin step(1'b0, 1'b0, 8'h00, 1'b0); n++; end
    check("tmo_first_launch", 32'(launched.size()), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin step(1'b0, 1'b0, 8'h00, 1'b0); n++; end
    check("tmo_cycles_to_idle", 32'(n), 32'(TMO + 1));
    check("tmo_flag", 32'(tx_timeout), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("tmo_next_newd", 32'(uart_newd), 32'd1);
    check("tmo_next_byte", 32'(uart_dintx), 32'h88);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("tmo_rst_clears", 32'(tx_timeout), 32'd0);
`endif

    // Randomized traffic with random responder latency and stray donetx pulses.
    auto_done = 1'b1; rand_delay = 1'b1; done_at = -1;
    n = 0;
    for (int i = 0; i < 800; i++) begin
      bit w;
      w = (i % 200 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(1'b0, w, byte_t'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
    end
    rand_delay = 1'b0; done_delay = 1;
    repeat (100) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("rand_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
